// File: rtl/dhcp_client_dbg_pkg.sv
// Shared types and default sizing for the dhcp_client dataflow deadlock supervisor.
package dhcp_client_dbg_pkg;

    localparam int DEF_NPROC  = 5;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_THRESH = 1024;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WATCH   = 3'd1,
        ST_CONFIRM = 3'd2,
        ST_SCAN    = 3'd3,
        ST_REPORT  = 3'd4,
        ST_HALT    = 3'd5
    } dl_state_t;

endpackage

// File: rtl/dhcp_client_hls_deadlock_sched_if.sv
// Deadlock report channel from the supervisor to the debug/CSR path.
// dl_timestamp exists only when DHCP_DEADLOCK_TRACE_EN is defined.
interface dhcp_client_hls_deadlock_sched_if #(
    parameter int NPROC = 5,
    parameter int IDX_W = $clog2(NPROC)
`ifdef DHCP_DEADLOCK_TRACE_EN
    ,
    parameter int CNT_W = 16
`endif
);

    // A report transfers on a cycle where dl_valid & dl_ready; once raised, dl_valid and the
    // payload hold steady until that transfer (or until clear/disable withdraws the report).
    logic             dl_valid;
    logic             dl_ready;
    logic [IDX_W-1:0] dl_proc_idx;
    logic [NPROC-1:0] dl_block_mask;
`ifdef DHCP_DEADLOCK_TRACE_EN
    logic [CNT_W-1:0] dl_timestamp;

    modport master (output dl_valid, dl_proc_idx, dl_block_mask, dl_timestamp, input dl_ready);
    modport slave  (input dl_valid, dl_proc_idx, dl_block_mask, dl_timestamp, output dl_ready);
`else
    modport master (output dl_valid, dl_proc_idx, dl_block_mask, input dl_ready);
    modport slave  (input dl_valid, dl_proc_idx, dl_block_mask, output dl_ready);
`endif

endinterface

// File: rtl/dhcp_client_dl_rr_scan.sv
// Round-robin scan pointer: loads a start index, then steps one process per cycle with wrap,
// flagging when the captured block mask has the current process set.
module dhcp_client_dl_rr_scan #(
    parameter int NPROC = 5,
    parameter int IDX_W = $clog2(NPROC)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [IDX_W-1:0] load_ptr,
    input  logic [NPROC-1:0] mask,
    output logic [IDX_W-1:0] ptr,
    output logic             found
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPROC - 1);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = load_ptr;
        end else if (step) begin
            ptr_d = (ptr_q == LAST_IDX) ? '0 : ptr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr   = ptr_q;
    assign found = mask[ptr_q];

endmodule

// File: rtl/dhcp_client_hls_deadlock_sched.sv
// Qualifies a persistent all-blocked-or-idle condition across the dataflow processes and reports
// one blocked culprit, chosen round-robin. Optional trace timestamp: DHCP_DEADLOCK_TRACE_EN.
module dhcp_client_hls_deadlock_sched
    import dhcp_client_dbg_pkg::*;
#(
    parameter int NPROC  = DEF_NPROC,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int THRESH = DEF_THRESH,
    parameter int IDX_W  = $clog2(NPROC)
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic                            clear,
    input  logic [NPROC-1:0]                proc_block,
    input  logic [NPROC-1:0]                proc_idle,
    output logic                            deadlock,
    dhcp_client_hls_deadlock_sched_if.master dl,
    output dl_state_t                       dbg_state,
    output logic [IDX_W-1:0]                dbg_rr_ptr
);

    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NPROC - 1);

    dl_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deadlock_q, deadlock_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NPROC-1:0] mask_q, mask_d;
    logic [IDX_W-1:0] rr_q, rr_d;

    logic             cond;
    logic             confirm;
    logic             scan_step;
    logic [IDX_W-1:0] scan_ptr;
    logic             scan_found;

    assign cond = (&(proc_block | proc_idle)) & (|proc_block);

    dhcp_client_dl_rr_scan #(
        .NPROC (NPROC),
        .IDX_W (IDX_W)
    ) u_scan (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (confirm),
        .step     (scan_step),
        .load_ptr (rr_q),
        .mask     (mask_q),
        .ptr      (scan_ptr),
        .found    (scan_found)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        deadlock_d = deadlock_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        mask_d     = mask_q;
        rr_d       = rr_q;
        confirm    = 1'b0;
        scan_step  = 1'b0;

        if (!enable) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            deadlock_d = 1'b0;
            valid_d    = 1'b0;
        end else if (clear && (state_q != ST_IDLE)) begin
            // clear beats a same-cycle dl_ready, so rr_q is deliberately left alone here
            state_d    = ST_WATCH;
            cnt_d      = '0;
            deadlock_d = 1'b0;
            valid_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WATCH;
                end
                ST_WATCH: begin
                    cnt_d = '0;
                    if (cond) begin
                        if (THRESH == 1) begin
                            confirm = 1'b1;
                        end else begin
                            state_d = ST_CONFIRM;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (!cond) begin
                        state_d = ST_WATCH;
                        cnt_d   = '0;
                    end else if (cnt_q == THRESH_M1) begin
                        confirm = 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SCAN: begin
                    if (scan_found) begin
                        idx_d   = scan_ptr;
                        valid_d = 1'b1;
                        state_d = ST_REPORT;
                    end else begin
                        scan_step = 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (dl.dl_ready) begin
                        valid_d = 1'b0;
                        rr_d    = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (confirm) begin
                state_d    = ST_SCAN;
                cnt_d      = '0;
                deadlock_d = 1'b1;
                mask_d     = proc_block;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            deadlock_q <= 1'b0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            mask_q     <= '0;
            rr_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            deadlock_q <= deadlock_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
            rr_q       <= rr_d;
        end
    end

`ifdef DHCP_DEADLOCK_TRACE_EN
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ts_q, ts_d;

    always_comb begin
        cyc_d = cyc_q + CNT_W'(1);
        ts_d  = confirm ? cyc_q : ts_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= '0;
            ts_q  <= '0;
        end else begin
            cyc_q <= cyc_d;
            ts_q  <= ts_d;
        end
    end

    assign dl.dl_timestamp = ts_q;
`endif

    assign deadlock         = deadlock_q;
    assign dl.dl_valid      = valid_q;
    assign dl.dl_proc_idx   = idx_q;
    assign dl.dl_block_mask = mask_q;
    assign dbg_state        = state_q;
    assign dbg_rr_ptr       = rr_q;

endmodule

// File: tb/tb_dhcp_client_hls_deadlock_sched.sv
// Bench for dhcp_client_hls_deadlock_sched: vector table, corner-case sequences, random traffic
// against a behavioural model (streak length + round-robin culprit distance).
module tb_dhcp_client_hls_deadlock_sched;
  import dhcp_client_dbg_pkg::*;

  localparam int NPROC  = 5;
  localparam int CNT_W  = 16;
  localparam int THRESH = 8;
  localparam int IDX_W  = $clog2(NPROC);

  localparam int PH_IDLE   = 0;
  localparam int PH_WATCH  = 1;
  localparam int PH_SCAN   = 2;
  localparam int PH_REPORT = 3;
  localparam int PH_HALT   = 4;

  logic             clock;
  logic             reset_n;
  logic             enable;
  logic             clear;
  logic [NPROC-1:0] proc_block;
  logic [NPROC-1:0] proc_idle;
  logic             deadlock;
  dl_state_t        dbg_state;
  logic [IDX_W-1:0] dbg_rr_ptr;

`ifdef DHCP_DEADLOCK_TRACE_EN
  dhcp_client_hls_deadlock_sched_if #(.NPROC(NPROC), .IDX_W(IDX_W), .CNT_W(CNT_W)) dl_if ();
`else
  dhcp_client_hls_deadlock_sched_if #(.NPROC(NPROC), .IDX_W(IDX_W)) dl_if ();
`endif

  dhcp_client_hls_deadlock_sched #(
    .NPROC  (NPROC),
    .CNT_W  (CNT_W),
    .THRESH (THRESH),
    .IDX_W  (IDX_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .proc_block (proc_block),
    .proc_idle  (proc_idle),
    .deadlock   (deadlock),
    .dl         (dl_if.master),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  int               m_phase;
  int               m_streak;
  int               m_wait;
  logic             m_dl;
  logic             m_v;
  logic [IDX_W-1:0] m_idx;
  logic [IDX_W-1:0] m_pend;
  logic [IDX_W-1:0] m_rr;
  logic [NPROC-1:0] m_mask;
  int               m_cyc;
  int               m_ts;
  logic [IDX_W-1:0] exp_q[$];

  typedef struct {
    logic             en;
    logic             clr;
    logic [NPROC-1:0] blk;
    logic [NPROC-1:0] idl;
    logic             rdy;
    int               n;
    logic             e_dl;
    logic             e_v;
    logic [IDX_W-1:0] e_idx;
    logic [NPROC-1:0] e_mask;
    logic [IDX_W-1:0] e_rr;
    dl_state_t        e_st;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic dl_state_t model_state();
    case (m_phase)
      PH_IDLE:   return ST_IDLE;
      PH_WATCH:  return (m_streak == 0) ? ST_WATCH : ST_CONFIRM;
      PH_SCAN:   return ST_SCAN;
      PH_REPORT: return ST_REPORT;
      default:   return ST_HALT;
    endcase
  endfunction

  task automatic model_reset();
    m_phase  = PH_IDLE;
    m_streak = 0;
    m_wait   = 0;
    m_dl     = 1'b0;
    m_v      = 1'b0;
    m_idx    = '0;
    m_pend   = '0;
    m_rr     = '0;
    m_mask   = '0;
    m_cyc    = 0;
    m_ts     = 0;
    exp_q.delete();
  endtask

  // Advances the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    bit               all_ok;
    bit               any_blk;
    bit               confirm;
    bit               found;
    logic [IDX_W-1:0] want;
    all_ok  = 1;
    any_blk = 0;
    confirm = 0;
    for (int i = 0; i < NPROC; i++) begin
      if (!proc_block[i] && !proc_idle[i]) all_ok = 0;
      if (proc_block[i]) any_blk = 1;
    end
    if (!enable || (clear && m_phase != PH_IDLE)) begin
      exp_q.delete();
      m_phase  = enable ? PH_WATCH : PH_IDLE;
      m_streak = 0;
      m_dl     = 1'b0;
      m_v      = 1'b0;
    end else begin
      case (m_phase)
        PH_IDLE: m_phase = PH_WATCH;
        PH_WATCH: begin
          if (all_ok && any_blk) begin
            m_streak++;
            if (m_streak == THRESH) confirm = 1;
          end else begin
            m_streak = 0;
          end
        end
        PH_SCAN: begin
          if (m_wait == 0) begin
            m_v     = 1'b1;
            m_idx   = m_pend;
            exp_q.push_back(m_pend);
            m_phase = PH_REPORT;
          end else begin
            m_wait--;
          end
        end
        PH_REPORT: begin
          if (dl_if.dl_ready) begin
            want = exp_q.pop_front();
            check("accept_valid", 32'(dl_if.dl_valid), 32'd1);
            check("accept_idx", 32'(dl_if.dl_proc_idx), 32'(want));
            m_rr    = IDX_W'((int'(m_idx) + 1) % NPROC);
            m_v     = 1'b0;
            m_phase = PH_HALT;
          end
        end
        default: ;
      endcase
    end
    if (confirm) begin
      m_dl     = 1'b1;
      m_mask   = proc_block;
      m_streak = 0;
      m_ts     = m_cyc;
      m_phase  = PH_SCAN;
      found    = 0;
      for (int k = 0; k < NPROC; k++) begin
        int j;
        j = (int'(m_rr) + k) % NPROC;
        if (proc_block[j] && !found) begin
          found  = 1;
          m_pend = IDX_W'(j);
          m_wait = k;
        end
      end
    end
    m_cyc = (m_cyc + 1) % (1 << CNT_W);
  endtask

  task automatic compare_all();
    check("deadlock", 32'(deadlock), 32'(m_dl));
    check("dl_valid", 32'(dl_if.dl_valid), 32'(m_v));
    check("dl_proc_idx", 32'(dl_if.dl_proc_idx), 32'(m_idx));
    check("dl_block_mask", 32'(dl_if.dl_block_mask), 32'(m_mask));
    check("rr_ptr", 32'(dbg_rr_ptr), 32'(m_rr));
    check("state", 32'(dbg_state), 32'(model_state()));
`ifdef DHCP_DEADLOCK_TRACE_EN
    check("dl_timestamp", 32'(dl_if.dl_timestamp), 32'(m_ts));
`endif
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic en, input logic clr, input logic [NPROC-1:0] blk,
                       input logic [NPROC-1:0] idl, input logic rdy);
    enable          = en;
    clear           = clr;
    proc_block      = blk;
    proc_idle       = idl;
    dl_if.dl_ready  = rdy;
  endtask

  task automatic expect_now(input string tag, input logic e_dl, input logic e_v,
                            input logic [IDX_W-1:0] e_idx, input logic [NPROC-1:0] e_mask,
                            input logic [IDX_W-1:0] e_rr, input dl_state_t e_st);
    check({tag, "_deadlock"}, 32'(deadlock), 32'(e_dl));
    check({tag, "_valid"}, 32'(dl_if.dl_valid), 32'(e_v));
    check({tag, "_idx"}, 32'(dl_if.dl_proc_idx), 32'(e_idx));
    check({tag, "_mask"}, 32'(dl_if.dl_block_mask), 32'(e_mask));
    check({tag, "_rr"}, 32'(dbg_rr_ptr), 32'(e_rr));
    check({tag, "_state"}, 32'(dbg_state), 32'(e_st));
  endtask

  // ---------------- test ----------------
  initial begin
    int run;

    // en clr blk idl rdy n | dl v idx mask rr state
    vecs.push_back('{1'b1, 1'b0, 5'b00000, 5'b11111, 1'b0, 1, 1'b0, 1'b0, 3'd0, 5'b00000, 3'd0, ST_WATCH});
    vecs.push_back('{1'b1, 1'b0, 5'b00100, 5'b11011, 1'b0, 7, 1'b0, 1'b0, 3'd0, 5'b00000, 3'd0, ST_CONFIRM});
    vecs.push_back('{1'b1, 1'b0, 5'b00100, 5'b11011, 1'b0, 1, 1'b1, 1'b0, 3'd0, 5'b00100, 3'd0, ST_SCAN});
    vecs.push_back('{1'b1, 1'b0, 5'b00100, 5'b11011, 1'b0, 2, 1'b1, 1'b0, 3'd0, 5'b00100, 3'd0, ST_SCAN});
    vecs.push_back('{1'b1, 1'b0, 5'b00100, 5'b11011, 1'b0, 1, 1'b1, 1'b1, 3'd2, 5'b00100, 3'd0, ST_REPORT});
    vecs.push_back('{1'b1, 1'b0, 5'b00100, 5'b11011, 1'b1, 1, 1'b1, 1'b0, 3'd2, 5'b00100, 3'd3, ST_HALT});
    vecs.push_back('{1'b1, 1'b0, 5'b00000, 5'b11111, 1'b0, 3, 1'b1, 1'b0, 3'd2, 5'b00100, 3'd3, ST_HALT});
    vecs.push_back('{1'b1, 1'b1, 5'b00101, 5'b11010, 1'b0, 1, 1'b0, 1'b0, 3'd2, 5'b00100, 3'd3, ST_WATCH});
    vecs.push_back('{1'b1, 1'b0, 5'b00101, 5'b11010, 1'b0, 8, 1'b1, 1'b0, 3'd2, 5'b00101, 3'd3, ST_SCAN});
    vecs.push_back('{1'b1, 1'b0, 5'b00101, 5'b11010, 1'b0, 2, 1'b1, 1'b0, 3'd2, 5'b00101, 3'd3, ST_SCAN});
    vecs.push_back('{1'b1, 1'b0, 5'b00101, 5'b11010, 1'b0, 1, 1'b1, 1'b1, 3'd0, 5'b00101, 3'd3, ST_REPORT});

    // reset
    reset_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    model_reset();
    #1;
    expect_now("reset", 1'b0, 1'b0, 3'd0, 5'b00000, 3'd0, ST_IDLE);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;

    // table: first detection, accept, clear, wrap-around culprit
    for (int r = 0; r < vecs.size(); r++) begin
      drive(vecs[r].en, vecs[r].clr, vecs[r].blk, vecs[r].idl, vecs[r].rdy);
      repeat (vecs[r].n) tick();
      expect_now($sformatf("vec%0d", r), vecs[r].e_dl, vecs[r].e_v, vecs[r].e_idx,
                 vecs[r].e_mask, vecs[r].e_rr, vecs[r].e_st);
    end

    // ready withheld in REPORT while live block flags churn
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b0, NPROC'($urandom_range(0, (1 << NPROC) - 1)), 5'b11111, 1'b0);
      tick();
      expect_now("stall", 1'b1, 1'b1, 3'd0, 5'b00101, 3'd3, ST_REPORT);
    end
    drive(1'b1, 1'b0, 5'b00000, 5'b11111, 1'b1);
    tick();
    expect_now("stall_acc", 1'b1, 1'b0, 3'd0, 5'b00101, 3'd1, ST_HALT);

    // persistence broken after 7 cycles, then re-held
    drive(1'b1, 1'b1, 5'b00010, 5'b11101, 1'b0);
    tick();
    clear = 1'b0;
    repeat (7) tick();
    check("persist7_deadlock", 32'(deadlock), 32'd0);
    proc_idle = 5'b00000;
    tick();
    check("break_state", 32'(dbg_state), 32'(ST_WATCH));
    proc_idle = 5'b11101;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("rehold%0d_deadlock", c), 32'(deadlock), (c == 8) ? 32'd1 : 32'd0);
    end
    tick();
    expect_now("fast_rep", 1'b1, 1'b1, 3'd1, 5'b00010, 3'd1, ST_REPORT);

    // clear and ready together: clear wins
    drive(1'b1, 1'b1, 5'b00010, 5'b11101, 1'b1);
    tick();
    expect_now("clr_rdy", 1'b0, 1'b0, 3'd1, 5'b00010, 3'd1, ST_WATCH);

    // enable dropped mid-CONFIRM
    drive(1'b1, 1'b0, 5'b01000, 5'b10111, 1'b0);
    repeat (4) tick();
    check("mid_confirm_state", 32'(dbg_state), 32'(ST_CONFIRM));
    enable = 1'b0;
    tick();
    expect_now("dis_confirm", 1'b0, 1'b0, 3'd1, 5'b00010, 3'd1, ST_IDLE);
    enable = 1'b1;
    tick();

    // enable dropped mid-REPORT
    repeat (8) tick();
    check("e_deadlock", 32'(deadlock), 32'd1);
    repeat (3) tick();
    expect_now("e_report", 1'b1, 1'b1, 3'd3, 5'b01000, 3'd1, ST_REPORT);
    enable = 1'b0;
    tick();
    expect_now("dis_report", 1'b0, 1'b0, 3'd3, 5'b01000, 3'd1, ST_IDLE);
    enable = 1'b1;
    tick();

    // asynchronous reset in the middle of a 5-step scan
    drive(1'b1, 1'b0, 5'b00001, 5'b11110, 1'b0);
    repeat (8) tick();
    repeat (2) tick();
    check("pre_reset_state", 32'(dbg_state), 32'(ST_SCAN));
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    expect_now("async_rst", 1'b0, 1'b0, 3'd0, 5'b00000, 3'd0, ST_IDLE);
    #1;
    reset_n = 1'b1;

    // randomized traffic against the model
    run = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run == 0) begin
        run        = $urandom_range(1, 20);
        proc_block = NPROC'($urandom_range(0, (1 << NPROC) - 1));
        if ($urandom_range(0, 3) != 0)
          proc_idle = ~proc_block | NPROC'($urandom_range(0, (1 << NPROC) - 1));
        else
          proc_idle = NPROC'($urandom_range(0, (1 << NPROC) - 1));
      end
      run--;
      enable         = ($urandom_range(0, 99) < 97);
      clear          = ($urandom_range(0, 99) < 3);
      dl_if.dl_ready = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dhcp_client_hls_deadlock_sched.md
# dhcp_client_hls_deadlock_sched

Supervisory controller for the per-process HLS deadlock monitors in the `dhcp_client` dataflow region. It takes the block and idle flags of every dataflow process and qualifies a deadlock only when the condition persists for a programmable number of cycles. It then scans for the blocked processes in round-robin order and reports one culprit index over a valid/ready handshake. It sits between the individual `*_deadlock_idx*_monitor` outputs and the debug/CSR path.

## Interface
- `NPROC`, 5: number of monitored dataflow processes (2..32)
- `CNT_W`, 16: persistence counter width
- `THRESH`, 1024: cycles the deadlock condition must hold (1..2^CNT_W-1)
- `IDX_W`, $clog2(NPROC): width of the reported index

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  arms detection; low forces IDLE
- `clear`  in  1  single-cycle pulse; releases a latched deadlock
- `proc_block`  in  NPROC  per-process block flag (monitor `block` outputs)
- `proc_idle`  in  NPROC  per-process idle flag
- `dl_valid`  out  1  report valid
- `dl_ready`  in  1  report accepted
- `dl_proc_idx`  out  IDX_W  index of the reported blocked process
- `dl_block_mask`  out  NPROC  snapshot of `proc_block` at confirmation
- `deadlock`  out  1  level; high from confirmation until `clear`

## Operation
- `cond` = (&(proc_block | proc_idle)) & (|proc_block): every process is blocked or idle, and at least one is blocked.
- States: IDLE, WATCH, CONFIRM, SCAN, REPORT, HALT.
- IDLE: if `enable`=1, go to WATCH next cycle.
- WATCH: counter=0. If `cond`, go to CONFIRM with counter=1.
- CONFIRM: counter increments while `cond` holds. If `cond` drops, go to WATCH with counter=0. When `cond` holds and counter=THRESH-1, capture `proc_block` into the mask, assert `deadlock`, load scan pointer from `rr_ptr`, and go to SCAN.
- SCAN: tests mask[ptr] once per cycle; ptr wraps NPROC-1→0. On the first set bit, latch `dl_proc_idx`=ptr and go to REPORT. The mask is guaranteed non-zero, so SCAN takes at most NPROC cycles.
- REPORT: `dl_valid`=1. `dl_proc_idx` and `dl_block_mask` are held stable. On `dl_valid & dl_ready`, set `rr_ptr`=(idx+1) mod NPROC and go to HALT.
- HALT: `deadlock` stays high. Live `proc_block` changes are ignored.
- Priority, highest first: `reset_n` low, then `enable`=0 (any state→IDLE, counter and `deadlock` cleared, `dl_valid` dropped without handshake), then `clear` (any non-IDLE state→WATCH, counter 0, `deadlock` 0, `dl_valid` 0), then normal transitions.
- Counter saturates and never wraps. THRESH=1 confirms on the first `cond` cycle in WATCH, going directly to SCAN.
- `rr_ptr` survives `clear` and `enable` toggles. Only reset zeroes it.

## Timing
- Reset values: `dl_valid`=0, `dl_proc_idx`=0, `dl_block_mask`=0, `deadlock`=0, state IDLE, `rr_ptr`=0, counter 0.
- All outputs are registered. There is no combinational path from any input to any output.
- Detection latency is exactly THRESH cycles from the first `cond` cycle sampled in WATCH to `deadlock` rising.
- Report latency: `dl_valid` rises 1..NPROC cycles after `deadlock`. It is 1 cycle when mask[rr_ptr] is set.
- `dl_valid` stays high until accepted, cleared, or disabled. Ready may be high before valid.
- If `clear` and `dl_ready` are both high in REPORT, `clear` wins, the handshake counts as not accepted, and `rr_ptr` is not updated.

## Configuration
- `DHCP_DEADLOCK_TRACE_EN` defined:
  - adds a free-running CNT_W-bit cycle counter (reset 0, wraps) and output `dl_timestamp` (CNT_W).
  - `dl_timestamp` captures the counter value on the confirmation cycle and is held with the report.
- Without the macro, neither the port nor the counter exists, and behaviour is otherwise identical.

## Structure
- Shared package `dhcp_client_dbg_pkg`: state enum `dl_state_t`, default NPROC, CNT_W, THRESH constants.
- One sub-module `dhcp_client_dl_rr_scan`: holds the scan pointer and mask test, with load/step/found signals. The FSM and persistence counter stay in the top module.

## Test plan
- NPROC=5, THRESH=8, blocks=5'b00100, idle=5'b11011 held → `deadlock` rises on cycle 8; `dl_valid` with idx=2, mask=00100; ready → HALT, `rr_ptr`=3.
- `cond` held for 7 cycles, broken 1 cycle, then re-held → no deadlock until 8 continuous cycles after re-assertion.
- After the first test, `clear`, then blocks=5'b00101 persistent → report idx=0 via wrap (`rr_ptr`=3, SCAN 3,4,0), so `dl_valid` comes 3 cycles after `deadlock`.
- `dl_ready` held low 20 cycles in REPORT while `proc_block` toggles → idx and mask stable, `dl_valid` stays high.
- `enable` deasserted mid-CONFIRM and mid-REPORT → IDLE next cycle, `dl_valid`=0, `deadlock`=0; `reset_n` pulsed mid-SCAN → all reset values immediately.
- `clear` and `dl_ready` together in REPORT → WATCH, `rr_ptr` unchanged. With `DHCP_DEADLOCK_TRACE_EN`, `dl_timestamp` equals the counter value at confirmation.
